// File: rtl/alu_seq_ctrl.sv
// Accumulator-based issue controller for a combinational ALU.
// Takes one operation per request handshake, enables the ALU for exactly one
// cycle, updates the accumulator and carry flag, and returns the captured
// result over a valid/ready response channel. It also flags ALU activity
// observed while the ALU is disabled.
module alu_seq_ctrl #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // Request channel
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [SIZE-1:0] req_operand_i,
  input  logic            req_use_carry_i,
  // ALU drive
  output logic            alu_ce_o,
  output logic [2:0]      alu_op_code_o,
  output logic [SIZE-1:0] alu_left_o,
  output logic [SIZE-1:0] alu_right_o,
  output logic            alu_carry_in_o,
  // ALU result
  input  logic [SIZE-1:0] alu_op_out_i,
  input  logic            alu_carry_out_i,
  // Response channel
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [SIZE-1:0] resp_result_o,
  output logic            resp_carry_o,
  // Architectural state
  output logic [SIZE-1:0] acc_o,
  output logic            carry_flag_o,
  output logic            alu_fault_o
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpSt  = 3'b111;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [SIZE-1:0] operand_q, operand_d;
  logic            cin_q, cin_d;
  logic [SIZE-1:0] result_q, result_d;
  logic            rcarry_q, rcarry_d;
  logic [SIZE-1:0] acc_q, acc_d;
  logic            carry_q, carry_d;
  logic            fault_q, fault_d;

  logic alu_ce;
  assign alu_ce = (state_q == StIssue);

  // Next-state: FSM sequencing, operand latch, result capture, fault tracking
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    cin_d     = cin_q;
    result_d  = result_q;
    rcarry_d  = rcarry_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    // Any nonzero ALU output while disabled is latched until reset
    fault_d   = fault_q | (~alu_ce & ((|alu_op_out_i) | alu_carry_out_i));

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          op_d      = req_op_i;
          operand_d = req_operand_i;
          // Carry-in is resolved at handshake time from the current flag
          cin_d     = req_use_carry_i & carry_q;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        result_d = alu_op_out_i;
        rcarry_d = alu_carry_out_i;
        if (op_q != OpSt) begin
          acc_d = alu_op_out_i;
        end
        if ((op_q == OpAdd) || (op_q == OpSub)) begin
          carry_d = alu_carry_out_i;
        end
        state_d = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      op_q      <= 3'b000;
      operand_q <= '0;
      cin_q     <= 1'b0;
      result_q  <= '0;
      rcarry_q  <= 1'b0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      operand_q <= operand_d;
      cin_q     <= cin_d;
      result_q  <= result_d;
      rcarry_q  <= rcarry_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      fault_q   <= fault_d;
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign alu_ce_o       = alu_ce;
  assign alu_op_code_o  = op_q;
  assign alu_left_o     = acc_q;
  assign alu_right_o    = operand_q;
  assign alu_carry_in_o = cin_q;
  assign resp_valid_o   = (state_q == StResp);
  assign resp_result_o  = result_q;
  assign resp_carry_o   = rcarry_q;
  assign acc_o          = acc_q;
  assign carry_flag_o   = carry_q;
  assign alu_fault_o    = fault_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU attached.
module tb_alu_seq_ctrl;

  localparam int unsigned SIZE = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [SIZE-1:0] req_operand;
  logic            req_use_carry;
  logic            alu_ce;
  logic [2:0]      alu_op_code;
  logic [SIZE-1:0] alu_left;
  logic [SIZE-1:0] alu_right;
  logic            alu_carry_in;
  logic [SIZE-1:0] alu_op_out;
  logic            alu_carry_out;
  logic            resp_valid;
  logic            resp_ready;
  logic [SIZE-1:0] resp_result;
  logic            resp_carry;
  logic [SIZE-1:0] acc;
  logic            carry_flag;
  logic            alu_fault;

  logic [SIZE-1:0] force_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.SIZE(SIZE)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_op_i        (req_op),
    .req_operand_i   (req_operand),
    .req_use_carry_i (req_use_carry),
    .alu_ce_o        (alu_ce),
    .alu_op_code_o   (alu_op_code),
    .alu_left_o      (alu_left),
    .alu_right_o     (alu_right),
    .alu_carry_in_o  (alu_carry_in),
    .alu_op_out_i    (alu_op_out),
    .alu_carry_out_i (alu_carry_out),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_result_o   (resp_result),
    .resp_carry_o    (resp_carry),
    .acc_o           (acc),
    .carry_flag_o    (carry_flag),
    .alu_fault_o     (alu_fault)
  );

  // Behavioural ALU: silent when disabled unless a fault value is forced
  always_comb begin
    logic [SIZE:0] sum;
    sum           = '0;
    alu_op_out    = force_val;
    alu_carry_out = 1'b0;
    if (alu_ce) begin
      case (alu_op_code)
        3'b000: sum = {1'b0, alu_left} + {1'b0, alu_right} + {{SIZE{1'b0}}, alu_carry_in};
        3'b001: sum = {1'b0, alu_left} - {1'b0, alu_right} + {{SIZE{1'b0}}, alu_carry_in};
        3'b010: sum = {1'b0, alu_left & alu_right};
        3'b011: sum = {1'b0, alu_left | alu_right};
        3'b100: sum = {1'b0, alu_left ^ alu_right};
        3'b101: sum = {1'b0, ~alu_left};
        3'b110: sum = {1'b0, alu_right};
        default: sum = {1'b0, alu_left};
      endcase
      alu_op_out    = sum[SIZE-1:0];
      alu_carry_out = sum[SIZE];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: handshake, issue cycle, response, accept
  task automatic do_op(input string tag, input logic [2:0] op, input logic [SIZE-1:0] opnd,
                       input logic uc, input logic [SIZE-1:0] exp_res, input logic exp_c,
                       input logic [SIZE-1:0] exp_acc, input logic exp_cf);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_op        = op;
    req_operand   = opnd;
    req_use_carry = uc;
    step();
    req_valid = 1'b0;
    check({tag, " ce_issue"}, 32'(alu_ce), 32'd1);
    check({tag, " no_early_resp"}, 32'(resp_valid), 32'd0);
    step();
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, " ce_off"}, 32'(alu_ce), 32'd0);
    check({tag, " result"}, 32'(resp_result), 32'(exp_res));
    check({tag, " resp_carry"}, 32'(resp_carry), 32'(exp_c));
    check({tag, " acc"}, 32'(acc), 32'(exp_acc));
    check({tag, " carry_flag"}, 32'(carry_flag), 32'(exp_cf));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check({tag, " back_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b1;
    req_valid     = 1'b0;
    req_op        = 3'b000;
    req_operand   = '0;
    req_use_carry = 1'b0;
    resp_ready    = 1'b0;
    force_val     = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst alu_ce", 32'(alu_ce), 32'd0);
    check("rst op_code", 32'(alu_op_code), 32'd0);
    check("rst left", 32'(alu_left), 32'd0);
    check("rst right", 32'(alu_right), 32'd0);
    check("rst cin", 32'(alu_carry_in), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_result", 32'(resp_result), 32'd0);
    check("rst acc", 32'(acc), 32'd0);
    check("rst carry_flag", 32'(carry_flag), 32'd0);
    check("rst fault", 32'(alu_fault), 32'd0);

    do_op("ld3c", 3'b110, 8'h3C, 1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0);
    check("left follows acc", 32'(alu_left), 32'h3C);

    // Carry chain
    do_op("ldf0",  3'b110, 8'hF0, 1'b0, 8'hF0, 1'b0, 8'hF0, 1'b0);
    do_op("add20", 3'b000, 8'h20, 1'b0, 8'h10, 1'b1, 8'h10, 1'b1);
    check("cin latched", 32'(alu_carry_in), 32'd0);
    do_op("adc01", 3'b000, 8'h01, 1'b1, 8'h12, 1'b0, 8'h12, 1'b0);
    check("cin used", 32'(alu_carry_in), 32'd1);

    // Borrow
    do_op("ld05",  3'b110, 8'h05, 1'b0, 8'h05, 1'b0, 8'h05, 1'b0);
    do_op("sub07", 3'b001, 8'h07, 1'b0, 8'hFE, 1'b1, 8'hFE, 1'b1);

    // Logic ops preserve carry_flag (currently 1)
    do_op("lda5",  3'b110, 8'hA5, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1);
    do_op("st",    3'b111, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b1);
    do_op("not",   3'b101, 8'h00, 1'b0, 8'h5A, 1'b0, 8'h5A, 1'b1);
    do_op("and0f", 3'b010, 8'h0F, 1'b0, 8'h0A, 1'b0, 8'h0A, 1'b1);
    do_op("or30",  3'b011, 8'h30, 1'b0, 8'h3A, 1'b0, 8'h3A, 1'b1);
    do_op("xorff", 3'b100, 8'hFF, 1'b0, 8'hC5, 1'b0, 8'hC5, 1'b1);

    // Backpressure: ADD 0x01 without carry on 0xC5 -> 0xC6
    req_valid = 1'b1; req_op = 3'b000; req_operand = 8'h01; req_use_carry = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      req_valid   = i[0];
      req_op      = 3'b110;
      req_operand = 8'h99;
      step();
      check("bp resp_valid", 32'(resp_valid), 32'd1);
      check("bp result", 32'(resp_result), 32'hC6);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp no_issue", 32'(alu_ce), 32'd0);
    end
    req_valid = 1'b0;
    check("bp acc", 32'(acc), 32'hC6);
    check("bp right", 32'(alu_right), 32'h01);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("bp release idle", 32'(req_ready), 32'd1);
    check("bp release valid", 32'(resp_valid), 32'd0);

    // Reset during RESP discards the response
    req_valid = 1'b1; req_op = 3'b110; req_operand = 8'h77;
    step();
    req_valid = 1'b0;
    step();
    check("rresp valid_before", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rresp resp_valid", 32'(resp_valid), 32'd0);
    check("rresp acc", 32'(acc), 32'd0);
    check("rresp req_ready", 32'(req_ready), 32'd1);
    check("no fault yet", 32'(alu_fault), 32'd0);

    // Sticky fault
    force_val = 8'h01;
    step();
    force_val = '0;
    check("fault set", 32'(alu_fault), 32'd1);
    step();
    step();
    check("fault sticky", 32'(alu_fault), 32'd1);
    do_op("ld11", 3'b110, 8'h11, 1'b0, 8'h11, 1'b0, 8'h11, 1'b0);
    check("fault after op", 32'(alu_fault), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("fault cleared", 32'(alu_fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Accumulator-based issue controller that drives the combinational ALU's CE/OP_CODE/operand/carry inputs and captures its result and carry. Upstream logic sends one operation per request over a valid/ready handshake. The block sequences the ALU for exactly one enabled cycle, updates its accumulator and carry flag, and returns the result over a valid/ready response channel. It also flags any ALU activity seen while CE is low.

## Interface
- SIZE, 8, datapath width; must match the ALU's SIZE
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  3  operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 LD, 111 ST
- req_operand  in  SIZE  right operand
- req_use_carry  in  1  1: ALU carry_in = carry_flag; 0: carry_in = 0
- alu_ce  out  1  ALU enable
- alu_op_code  out  3  ALU OP_CODE
- alu_left  out  SIZE  ALU left_operand (always the accumulator)
- alu_right  out  SIZE  ALU right_operand
- alu_carry_in  out  1  ALU carry_in
- alu_op_out  in  SIZE  ALU result
- alu_carry_out  in  1  ALU carry_out
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_result  out  SIZE  captured ALU result
- resp_carry  out  1  captured ALU carry_out
- acc  out  SIZE  accumulator
- carry_flag  out  1  carry flag
- alu_fault  out  1  sticky: ALU output nonzero while alu_ce = 0

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: req_ready = 1. A handshake (req_valid & req_ready) registers req_op, req_operand and the selected carry-in, then goes to ISSUE.
- ISSUE (exactly 1 cycle): alu_ce = 1.
  - At the end of the cycle, capture alu_op_out into resp_result and alu_carry_out into resp_carry. Go to RESP.
  - ST: acc unchanged; the result equals acc.
  - All other ops: acc <= alu_op_out.
  - carry_flag <= alu_carry_out for ADD/SUB only. The other ops preserve carry_flag.
- RESP: resp_valid = 1. resp_result and resp_carry are held stable until resp_valid & resp_ready, then the FSM returns to IDLE.
- req_ready = 0 in ISSUE and RESP. req_valid is ignored there.
- Arithmetic is performed by the ALU and is (SIZE+1)-bit:
  - ADD: {c,r} = acc + operand + cin.
  - SUB: {c,r} = acc - operand + cin. c = 1 indicates a borrow/wrap.
  - No saturation.
- ALU outputs (alu_op_code, alu_right, alu_carry_in) stay at their registered values outside ISSUE. They change only on a request handshake.
- alu_fault:
  - Set when alu_ce = 0 and (alu_op_out != 0 or alu_carry_out != 0).
  - Cleared only by rst.
  - Not sampled in the reset cycle.

## Timing
- Reset values: state IDLE; req_ready 1; alu_ce 0; alu_op_code 000; alu_left 0; alu_right 0; alu_carry_in 0; resp_valid 0; resp_result 0; resp_carry 0; acc 0; carry_flag 0; alu_fault 0.
- Latency: handshake in cycle N → alu_ce high in N+1 → resp_valid high in N+2.
- Minimum issue interval is 3 cycles, reached when resp_ready is held high.
- A handshake in IDLE never coincides with a response; there is no overlap.
- rst has priority in every state:
  - rst in ISSUE: no acc/carry update.
  - rst in RESP: the pending response is discarded, and resp_valid = 0 in the next cycle.
- alu_left = acc combinationally from the register.
  - An acc update at the end of ISSUE is visible from N+2.
- Back-to-back ops use the updated acc and carry_flag.

## Test plan
- After rst, LD 0x3C: resp_valid at N+2 with resp_result 0x3C, resp_carry 0; acc 0x3C; alu_ce high only in N+1.
- Carry chain:
  - acc 0xF0, ADD 0x20 with use_carry 0 → result 0x10, carry_flag 1.
  - Then ADD 0x01 with use_carry 1 → result 0x12, carry_flag 0.
- acc 0x05, SUB 0x07 with use_carry 0 → result 0xFE, resp_carry 1, acc 0xFE.
- acc 0xA5:
  - ST → result 0xA5, acc stays 0xA5, carry_flag unchanged.
  - NOT → result 0x5A, acc 0x5A.
  - AND 0x0F on 0x5A → 0x0A.
- Backpressure: resp_ready held 0 for 5 cycles with req_valid pulsed meanwhile → result stable, req_ready 0, no second issue. With resp_ready = 1 → IDLE the next cycle.
- rst asserted during RESP → next cycle resp_valid 0, acc 0, req_ready 1. Separately, forcing alu_op_out = 0x01 while alu_ce = 0 → alu_fault rises and stays 1 until rst.
